// File: rtl/ahb_mem_sram_ctrl_pkg.sv
// Shared types and constants for the AHB memory-side SRAM controller.
package ahb_mem_sram_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_BUSY = 2'd1,
        RD_BUSY = 2'd2,
        RD_RESP = 2'd3
    } state_t;

    localparam int DEF_RD_LATENCY = 2;
    localparam int DEF_WR_WAIT    = 0;

    // Byte-offset bits dropped from the byte address to form a word index.
    function automatic int lsb_shift(input int data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/ahb_mem_sram_ctrl_if.sv
// Memory request/response port between ahb_slave (master) and the SRAM controller (slave).
interface ahb_mem_sram_ctrl_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  i_valid;
    logic                  i_rd0_wr1;
    logic [ADDR_WIDTH-1:0] i_addr;
    logic [DATA_WIDTH-1:0] i_wr_data;
    logic                  o_ready;
    logic                  o_rd_valid;
    logic [DATA_WIDTH-1:0] o_rd_data;
    logic                  o_err_sticky;

    modport master (
        output i_valid, i_rd0_wr1, i_addr, i_wr_data,
        input  o_ready, o_rd_valid, o_rd_data, o_err_sticky
    );

    modport slave (
        input  i_valid, i_rd0_wr1, i_addr, i_wr_data,
        output o_ready, o_rd_valid, o_rd_data, o_err_sticky
    );
endinterface

// File: rtl/ahb_mem_sram_ctrl_sram_1rw.sv
// Single-port word-wide SRAM array, no reset.
// Latency: read data appears one edge after an enabled read.
// Backpressure: none; one access per enabled edge, a write leaves rdata unchanged.
module ahb_mem_sram_ctrl_sram_1rw #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024,
    parameter int IW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [IW-1:0]         addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end
endmodule

// File: rtl/ahb_mem_sram_ctrl.sv
// Memory-side responder for ahb_slave: owns the SRAM, programmable read latency and write waits.
// Latency: read response RD_LATENCY cycles after accept; writes commit at accept or after WR_WAIT cycles.
// Backpressure: o_ready low in WR_BUSY/RD_BUSY; requests offered while not ready are ignored.
module ahb_mem_sram_ctrl
    import ahb_mem_sram_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 1024,
    parameter int RD_LATENCY = DEF_RD_LATENCY,
    parameter int WR_WAIT    = DEF_WR_WAIT
) (
    input  logic                i_clk_ahb,
    input  logic                i_rstn_ahb,
    ahb_mem_sram_ctrl_if.slave  bus
);
    localparam int LSB     = lsb_shift(DATA_WIDTH);
    localparam int IW      = $clog2(DEPTH);
    localparam int CNT_MAX = (RD_LATENCY > WR_WAIT) ? RD_LATENCY : WR_WAIT;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] RD_LOAD = CW'((RD_LATENCY > 1) ? RD_LATENCY - 2 : 0);
    localparam logic [CW-1:0] WR_LOAD = CW'((WR_WAIT > 0) ? WR_WAIT - 1 : 0);

    state_t                state, state_nxt;
    logic [CW-1:0]         cnt, cnt_nxt;
    logic                  ready, rd_vld, accept;
    logic [IW-1:0]         in_idx, req_idx;
    logic                  in_oor, in_wr, req_oor, err;
    logic [DATA_WIDTH-1:0] req_dat, last_dat, rd_dat, sram_q;
    logic                  mem_en, mem_we;
    logic [IW-1:0]         mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdat;

    assign in_idx = bus.i_addr[LSB +: IW];
    assign in_oor = |bus.i_addr[ADDR_WIDTH-1:LSB+IW];
    assign in_wr  = bus.i_rd0_wr1;
    assign accept = bus.i_valid & ready;

    if (LSB > 0) begin : g_lsb
        logic unused_addr_lsb;
        assign unused_addr_lsb = ^bus.i_addr[LSB-1:0];
    end

    // RD_RESP accepts a new request exactly like IDLE, so both share one branch.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ready     = 1'b0;
        rd_vld    = 1'b0;
        case (state)
            IDLE, RD_RESP: begin
                ready     = 1'b1;
                rd_vld    = (state == RD_RESP);
                state_nxt = IDLE;
                if (bus.i_valid) begin
                    if (in_wr) begin
                        if (WR_WAIT > 0) begin
                            state_nxt = WR_BUSY;
                            cnt_nxt   = WR_LOAD;
                        end
                    end else if (RD_LATENCY > 1) begin
                        state_nxt = RD_BUSY;
                        cnt_nxt   = RD_LOAD;
                    end else begin
                        state_nxt = RD_RESP;
                    end
                end
            end
            WR_BUSY: begin
                if (cnt == '0) state_nxt = IDLE;
                else           cnt_nxt   = cnt - CW'(1);
            end
            RD_BUSY: begin
                if (cnt == '0) state_nxt = RD_RESP;
                else           cnt_nxt   = cnt - CW'(1);
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Busy states re-read the captured word each edge so the data landing in RD_RESP is current.
    always_comb begin
        mem_en   = 1'b0;
        mem_we   = 1'b0;
        mem_addr = in_idx;
        mem_wdat = bus.i_wr_data;
        if (state == WR_BUSY) begin
            mem_addr = req_idx;
            mem_wdat = req_dat;
            mem_en   = (cnt == '0) & ~req_oor;
            mem_we   = 1'b1;
        end else if (state == RD_BUSY) begin
            mem_addr = req_idx;
            mem_en   = 1'b1;
        end else if (accept) begin
            mem_en   = ~(in_wr & (in_oor | (WR_WAIT > 0)));
            mem_we   = in_wr;
        end
    end

    always_ff @(posedge i_clk_ahb or negedge i_rstn_ahb) begin
        if (!i_rstn_ahb) begin
            state    <= IDLE;
            cnt      <= '0;
            req_idx  <= '0;
            req_dat  <= '0;
            req_oor  <= 1'b0;
            last_dat <= '0;
            err      <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                req_idx <= in_idx;
                req_dat <= bus.i_wr_data;
                req_oor <= in_oor;
                if (in_oor) err <= 1'b1;
            end
            if (rd_vld) last_dat <= rd_dat;
        end
    end

    assign rd_dat = rd_vld ? (req_oor ? '0 : sram_q) : last_dat;

    ahb_mem_sram_ctrl_sram_1rw #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_sram (
        .clk   (i_clk_ahb),
        .en    (mem_en),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (mem_wdat),
        .rdata (sram_q)
    );

    assign bus.o_ready      = ready;
    assign bus.o_rd_valid   = rd_vld;
    assign bus.o_rd_data    = rd_dat;
    assign bus.o_err_sticky = err;
endmodule

// File: tb/tb_ahb_mem_sram_ctrl.sv
// Scoreboard bench: dut_a (RD_LATENCY=2, WR_WAIT=0) and dut_b (RD_LATENCY=1, WR_WAIT=3).
module tb_ahb_mem_sram_ctrl;
    localparam int DW = 32, AW = 32, DEPTH = 1024, IW = 10;
    localparam int LAT_A = 2, WAIT_A = 0, LAT_B = 1, WAIT_B = 3;

    typedef struct packed {
        logic [0:0]  dut;
        logic [31:0] dat;
        logic [31:0] due;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        valid [2], wr [2], ready [2], rvld [2], err [2];
    logic [31:0] addr [2], wdata [2], rdata [2];
    int          lat [2] = '{LAT_A, LAT_B};

    exp_t        sb [$];
    logic [31:0] mdl [2][DEPTH];
    logic        err_exp [2];
    logic [31:0] last_exp [2];
    int          n_chk = 0, n_err = 0;

    ahb_mem_sram_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_a ();
    ahb_mem_sram_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_b ();

    assign bus_a.i_valid   = valid[0];
    assign bus_a.i_rd0_wr1 = wr[0];
    assign bus_a.i_addr    = addr[0];
    assign bus_a.i_wr_data = wdata[0];
    assign ready[0]        = bus_a.o_ready;
    assign rvld[0]         = bus_a.o_rd_valid;
    assign rdata[0]        = bus_a.o_rd_data;
    assign err[0]          = bus_a.o_err_sticky;
    assign bus_b.i_valid   = valid[1];
    assign bus_b.i_rd0_wr1 = wr[1];
    assign bus_b.i_addr    = addr[1];
    assign bus_b.i_wr_data = wdata[1];
    assign ready[1]        = bus_b.o_ready;
    assign rvld[1]         = bus_b.o_rd_valid;
    assign rdata[1]        = bus_b.o_rd_data;
    assign err[1]          = bus_b.o_err_sticky;

    ahb_mem_sram_ctrl #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .RD_LATENCY(LAT_A), .WR_WAIT(WAIT_A)
    ) dut_a (
        .i_clk_ahb  (clk),
        .i_rstn_ahb (rst_n),
        .bus        (bus_a)
    );

    ahb_mem_sram_ctrl #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .RD_LATENCY(LAT_B), .WR_WAIT(WAIT_B)
    ) dut_b (
        .i_clk_ahb  (clk),
        .i_rstn_ahb (rst_n),
        .bus        (bus_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Offer one request to DUT d, wait for the accept edge, then update the model.
    task automatic req(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd);
        int          n = 0;
        logic [31:0] idx;
        logic        oor;
        exp_t        e;
        @(negedge clk);
        while (!ready[d] && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!ready[d]) chk("ready_timeout", 32'(ready[d]), 32'd1);
        valid[d] = 1'b1;
        wr[d]    = w;
        addr[d]  = a;
        wdata[d] = wd;
        @(posedge clk);
        #1;
        valid[d] = 1'b0;
        idx = a >> 2;
        oor = (idx >= DEPTH);
        if (oor) err_exp[d] = 1'b1;
        if (w) begin
            if (!oor) mdl[d][idx[IW-1:0]] = wd;
        end else begin
            e.dut = d[0];
            e.dat = oor ? 32'd0 : mdl[d][idx[IW-1:0]];
            e.due = cyc + lat[d] - 1;
            sb.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            for (int d = 0; d < 2; d++) begin
                if (rvld[d]) begin
                    if (sb.size() == 0 || int'(sb[0].dut) != d) begin
                        chk("rvld_unexpected", 32'(rvld[d]), 32'd0);
                    end else begin
                        e = sb.pop_front();
                        chk("rd_data", rdata[d], e.dat);
                        chk("rd_cycle", cyc, e.due);
                        last_exp[d] = e.dat;
                    end
                end else begin
                    chk("rd_data_hold", rdata[d], last_exp[d]);
                    if (sb.size() > 0 && int'(sb[0].dut) == d && cyc > sb[0].due) begin
                        chk("rvld_missing", 32'(rvld[d]), 32'd1);
                        void'(sb.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

    initial begin
        int unsigned t;
        for (int d = 0; d < 2; d++) begin
            valid[d] = 1'b0; wr[d] = 1'b0; addr[d] = '0; wdata[d] = '0;
            err_exp[d] = 1'b0; last_exp[d] = '0;
        end
        idle(3);
        chk("rst_ready",   32'(ready[0]), 32'd1);
        chk("rst_rvld",    32'(rvld[0]),  32'd0);
        chk("rst_rdata",   rdata[0],      32'd0);
        chk("rst_err",     32'(err[0]),   32'd0);
        chk("rst_ready_b", 32'(ready[1]), 32'd1);
        rst_n = 1'b1;

        // Write then read, latency 2 on dut_a
        req(0, 1'b1, 32'h10, 32'hA5A5_0001);
        req(0, 1'b0, 32'h10, 32'h0);
        idle(4);

        // Back-to-back writes, then a read issued in RD_RESP of the previous one
        req(0, 1'b1, 32'h4, 32'h0404_0404);
        t = cyc;
        req(0, 1'b1, 32'h8, 32'h0808_0808);
        chk("wr_b2b_gap", cyc - t, 32'd1);
        req(0, 1'b0, 32'h4, 32'h0);
        t = cyc;
        req(0, 1'b0, 32'h8, 32'h0);
        chk("rd_b2b_gap", cyc - t, 32'(LAT_A));
        idle(4);

        // Low address bits are ignored
        req(0, 1'b1, 32'h10, 32'h1234_5678);
        req(0, 1'b0, 32'h13, 32'h0);
        idle(4);

        // Write wait states on dut_b; requests offered while busy must be ignored
        req(1, 1'b1, 32'h0, 32'h5A5A_0000);
        valid[1] = 1'b1; wr[1] = 1'b1; addr[1] = 32'h0; wdata[1] = 32'hDEAD_BEEF;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("wr_wait_ready", 32'(ready[1]), (i < 3) ? 32'd0 : 32'd1);
        end
        valid[1] = 1'b0;
        req(1, 1'b0, 32'h0, 32'h0);
        t = cyc;
        req(1, 1'b0, 32'h0, 32'h0);
        chk("rd_b2b_gap_b", cyc - t, 32'(LAT_B));
        idle(4);

        // Out-of-range write and read; word 0 must not alias
        req(0, 1'b1, 32'h0, 32'h0000_CAFE);
        req(0, 1'b1, DEPTH * 4, 32'hBAD0_BAD0);
        @(negedge clk);
        chk("err_after_oor_wr", 32'(err[0]), 32'(err_exp[0]));
        req(0, 1'b0, DEPTH * 4, 32'h0);
        req(0, 1'b0, 32'h0, 32'h0);
        idle(4);
        chk("err_sticky_a", 32'(err[0]), 32'(err_exp[0]));
        chk("err_clear_b",  32'(err[1]), 32'(err_exp[1]));

        // Reset while dut_a sits in RD_BUSY: the pending read is dropped
        req(0, 1'b0, 32'h10, 32'h0);
        chk("rd_busy_ready", 32'(ready[0]), 32'd0);
        rst_n = 1'b0;
        void'(sb.pop_back());
        for (int d = 0; d < 2; d++) begin
            err_exp[d] = 1'b0;
            last_exp[d] = '0;
        end
        idle(2);
        chk("rstmid_rvld", 32'(rvld[0]), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 32'(ready[0]), 32'd1);
        chk("post_rst_rdata", rdata[0], 32'd0);
        chk("post_rst_err",   32'(err[0]), 32'(err_exp[0]));
        idle(6);
        chk("sb_drain", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
